// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: clamped width commands, frame-aligned updates.
// Optional `SERVO_SLEW_LIMIT_EN limits active width change per frame.
module servo_pwm_gen #(
  parameter int CLK_PER_US  = 1,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int MAX_STEP_US = 20
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [11:0] width_us,
  input  logic        width_valid,
  output logic        width_ready,
  input  logic        enable,
  output logic        pwm_out,
  output logic        frame_start,
  output logic [14:0] frame_cnt,
  output logic [11:0] active_us,
  output logic        clamped
);

  localparam int PW =
    (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(CLK_PER_US - 1);
  localparam logic [14:0] FRAME_LAST =
    15'(FRAME_US - 1);
  localparam logic [11:0] MIN_W = 12'(MIN_US);
  localparam logic [11:0] MAX_W = 12'(MAX_US);

  if (!(CLK_PER_US > 0 && MAX_STEP_US > 0 &&
        MIN_US <= MAX_US && MAX_US < FRAME_US &&
        FRAME_US <= 32767)) begin : g_bad_cfg
    $error("servo_pwm_gen: illegal parameters");
  end

  logic [PW-1:0] r_presc;
  logic [11:0]   r_shadow;
  logic          r_full;
  logic          r_en_q;

  logic          w_tick;
  logic          w_bound;
  logic          w_accept;
  logic          w_load;
  logic          w_oor;
  logic [11:0]   w_clamp;
  logic [11:0]   w_act_nxt;
  logic [14:0]   w_frame_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_en_nxt;
  logic          w_pwm_nxt;

  assign width_ready = !r_full;
  assign w_tick      = (r_presc == PRE_LAST);
  assign w_bound     = w_tick && (frame_cnt == FRAME_LAST);
  assign w_accept    = width_valid && !r_full;
  assign w_load      = w_bound && r_full;

  always_comb begin
    w_oor   = (r_shadow < MIN_W) || (r_shadow > MAX_W);
    w_clamp = r_shadow;
    if (r_shadow < MIN_W) w_clamp = MIN_W;
    if (r_shadow > MAX_W) w_clamp = MAX_W;
  end

  always_comb begin
    w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
    w_frame_nxt = frame_cnt;
    if (w_bound)     w_frame_nxt = '0;
    else if (w_tick) w_frame_nxt = frame_cnt + 15'd1;
    w_en_nxt = w_bound ? enable : r_en_q;
  end

`ifdef SERVO_SLEW_LIMIT_EN
  localparam logic [11:0] STEP_W = 12'(MAX_STEP_US);

  logic [11:0] r_target;
  logic [11:0] w_tgt_nxt;
  logic [11:0] w_diff;
  logic [11:0] w_step;
  logic        w_up;

  // Step toward the target once per frame, never overshooting.
  always_comb begin
    w_tgt_nxt = w_load ? w_clamp : r_target;
    w_up      = (w_tgt_nxt > active_us);
    w_diff    = w_up ? (w_tgt_nxt - active_us)
                     : (active_us - w_tgt_nxt);
    w_step    = (w_diff > STEP_W) ? STEP_W : w_diff;
    w_act_nxt = active_us;
    if (w_bound)
      w_act_nxt = w_up ? (active_us + w_step)
                       : (active_us - w_step);
  end
`else
  assign w_act_nxt = w_load ? w_clamp : active_us;
`endif

  // Pulse is aligned to the next-state frame position.
  assign w_pwm_nxt =
    w_en_nxt && (w_frame_nxt < {3'b000, w_act_nxt});

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      r_presc     <= '0;
      frame_cnt   <= '0;
      active_us   <= MIN_W;
      r_shadow    <= '0;
      r_full      <= 1'b0;
      r_en_q      <= 1'b0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      clamped     <= 1'b0;
`ifdef SERVO_SLEW_LIMIT_EN
      r_target    <= MIN_W;
`endif
    end else begin
      r_presc     <= w_presc_nxt;
      frame_cnt   <= w_frame_nxt;
      active_us   <= w_act_nxt;
      r_en_q      <= w_en_nxt;
      pwm_out     <= w_pwm_nxt;
      frame_start <= w_bound;
`ifdef SERVO_SLEW_LIMIT_EN
      r_target    <= w_tgt_nxt;
`endif
      if (w_load) begin
        clamped <= w_oor;
        r_full  <= 1'b0;
      end
      if (w_accept) begin
        r_shadow <= width_us;
        r_full   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: frame-level reference model,
// randomized commands and enable toggles, monitor on frame_start.
module tb_servo_pwm_gen;

  localparam int C    = 2;
  localparam int F    = 200;
  localparam int MIN  = 50;
  localparam int MAX  = 100;
  localparam int STEP = 5;
  localparam int P    = F * C;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic [11:0] width_us;
  logic        width_valid;
  logic        width_ready;
  logic        enable;
  logic        pwm_out;
  logic        frame_start;
  logic [14:0] frame_cnt;
  logic [11:0] active_us;
  logic        clamped;

  always #5 mclk = ~mclk;

  servo_pwm_gen #(
    .CLK_PER_US (C),
    .FRAME_US   (F),
    .MIN_US     (MIN),
    .MAX_US     (MAX),
    .MAX_STEP_US(STEP)
  ) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .width_us   (width_us),
    .width_valid(width_valid),
    .width_ready(width_ready),
    .enable     (enable),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt),
    .active_us  (active_us),
    .clamped    (clamped)
  );

  typedef struct {
    int act;
    int cl;
    int high;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int clampw(input int w);
    if (w < MIN) return MIN;
    if (w > MAX) return MAX;
    return w;
  endfunction

  // Reference model: absolute cycle count since reset release.
  bit run = 0;
  int t, m_full, m_shadow, m_act, m_cl, m_en, m_tgt;

  initial forever begin
    @(posedge mclk);
    if (run) begin
      int old_full;
      old_full = m_full;
      if (t % P == P - 1) begin
        if (m_full != 0) begin
          m_cl = (m_shadow < MIN || m_shadow > MAX) ? 1 : 0;
`ifdef SERVO_SLEW_LIMIT_EN
          m_tgt = clampw(m_shadow);
`else
          m_act = clampw(m_shadow);
`endif
          m_full = 0;
        end
`ifdef SERVO_SLEW_LIMIT_EN
        if (m_tgt > m_act)
          m_act += (m_tgt - m_act > STEP) ? STEP : m_tgt - m_act;
        else
          m_act -= (m_act - m_tgt > STEP) ? STEP : m_act - m_tgt;
`endif
        m_en = enable ? 1 : 0;
        q.push_back('{m_act, m_cl, m_en != 0 ? m_act * C : 0});
      end
      if (width_valid && old_full == 0) begin
        m_full   = 1;
        m_shadow = int'(width_us);
      end
      t++;
    end
  end

  // Monitor: one scoreboard entry per frame, opened on frame_start.
  bit   first = 0;
  int   frames = 0;
  exp_t cur = '{MIN, 0, 0};
  int   c, hi, bad_pwm, bad_cnt, bad_rdy;

  initial forever begin
    @(negedge mclk);
    if (run) begin
      if (first || frame_start) begin
        if (!first) begin
          chk("frame_len", c, P);
          chk("pwm_high", hi, cur.high);
          chk("pwm_shape", bad_pwm, 0);
          chk("frame_cnt", bad_cnt, 0);
          chk("width_ready", bad_rdy, 0);
        end
        first = 0;
        if (q.size() == 0) begin
          chk("scoreboard_empty", q.size(), 1);
        end else begin
          cur = q.pop_front();
        end
        chk("active_us", int'(active_us), cur.act);
        chk("clamped", int'(clamped), cur.cl);
        c = 0; hi = 0;
        bad_pwm = 0; bad_cnt = 0; bad_rdy = 0;
        frames++;
      end
      if (pwm_out) hi++;
      if (pwm_out != (c < cur.high)) bad_pwm++;
      if (int'(frame_cnt) != c / C) bad_cnt++;
      if (width_ready != (m_full == 0)) bad_rdy++;
      c++;
    end
  end

  task automatic step();
    @(posedge mclk);
    #2;
  endtask

  task automatic release_reset();
    q.delete();
    t = 0; m_full = 0; m_shadow = 0;
    m_act = MIN; m_cl = 0; m_en = 0; m_tgt = MIN;
    q.push_back('{MIN, 0, 0});
    first = 1;
    rst_n = 1'b1;
    run   = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pwm_out"}, int'(pwm_out), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    chk({tag, "_active_us"}, int'(active_us), MIN);
    chk({tag, "_clamped"}, int'(clamped), 0);
    chk({tag, "_width_ready"}, int'(width_ready), 1);
  endtask

  task automatic send(input int w);
    int n = 0;
    width_us    = 12'(w);
    width_valid = 1'b1;
    while (!width_ready && n < 3 * P) begin
      step();
      n++;
    end
    chk("ready_timeout", int'(width_ready), 1);
    step();
    width_valid = 1'b0;
    width_us    = 12'($urandom);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 2 * P);
    chk("frame_timeout", int'(frame_start), 1);
  endtask

  task automatic wait_frames(input int k);
    for (int i = 0; i < k; i++) wait_frame();
  endtask

  function automatic int rand_width();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 4095));
      1, 2: return int'($urandom_range(MIN, MAX));
      default: begin
        case ($urandom_range(0, 5))
          0: return 0;
          1: return MIN - 1;
          2: return MIN;
          3: return MAX;
          4: return MAX + 1;
          default: return 4095;
        endcase
      end
    endcase
  endfunction

  initial begin
    int n;
    rst_n       = 1'b0;
    width_valid = 1'b0;
    width_us    = '0;
    enable      = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    release_reset();

    enable = 1'b1;
    wait_frames(3);
    send(75);
    wait_frames(2);
    send(150);
    wait_frames(1);
    send(0);
    wait_frames(1);
    send(60);
    wait_frames(2);
    send(65);
    send(85);
    wait_frames(3);

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, P - 1)) step();
      case ($urandom_range(0, 4))
        0: ;
        1: send(rand_width());
        2: begin
          send(rand_width());
          send(rand_width());
        end
        3: enable = ~enable;
        default: begin
          wait_frame();
          repeat (P - 1) step();
          send(rand_width());
        end
      endcase
    end

    enable = 1'b1;
    send(90);
    wait_frames(3);
    n = 0;
    while (int'(frame_cnt) != 70 && n < 2 * P) begin
      step();
      n++;
    end
    chk("pulse_before_reset", int'(pwm_out), 1);
    rst_n = 1'b0;
    run   = 0;
    step();
    check_reset_vals("midpulse_reset");
    release_reset();
    wait_frames(3);
    chk("frames_seen", int'(frames >= 40), 1);

    run = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
